// File: rtl/pelican_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : pelican_pkg                                               |
// | Purpose  : Shared types, widths and round-constant step function for |
// |            the Pelican MAC round sequencer.                          |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
package pelican_pkg;

  localparam int STATE_W = 128;
  localparam int KEY_W   = 64;
  localparam int WORD_W  = 32;
  localparam int RC_W    = 6;
  localparam int CNT_W   = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    TAG   = 2'd2
  } fsm_t;

  // One step of the 6-bit round-constant LFSR.
  function automatic logic [RC_W-1:0] rc_next(input logic [RC_W-1:0] r);
    return {r[4:0], r[5] ^ r[4]};
  endfunction

endpackage : pelican_pkg
`default_nettype wire

// File: rtl/pelican_round_ctrl_rc_lfsr.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : pelican_rc_lfsr                                           |
// | Purpose  : 6-bit round-constant register. Reloads the initial value  |
// |            at the start of every block and steps once per round.     |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module pelican_rc_lfsr
  import pelican_pkg::*;
#(
  parameter logic [RC_W-1:0] RC_INIT = 6'h01
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_load,
  input  logic            i_step,
  output logic [RC_W-1:0] o_rc
);

  logic [RC_W-1:0] r_rc;

  // Load has priority so a new block always starts from RC_INIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rc <= RC_INIT;
    end else if (i_load) begin
      r_rc <= RC_INIT;
    end else if (i_step) begin
      r_rc <= rc_next(r_rc);
    end
  end

  assign o_rc = r_rc;

endmodule : pelican_rc_lfsr
`default_nettype wire

// File: rtl/pelican_round_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : pelican_round_ctrl                                        |
// | Purpose  : Pelican MAC sequencer. Absorbs 128-bit blocks into the    |
// |            chaining state, runs NR rounds through an external        |
// |            combinational round function, presents the tag after the  |
// |            final block.                                              |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module pelican_round_ctrl
  import pelican_pkg::*;
#(
  parameter int              NR      = 4,
  parameter logic [RC_W-1:0] RC_INIT = 6'h01
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_key_we,
  input  logic [KEY_W-1:0]   i_key,
  input  logic               i_blk_valid,
  output logic               o_blk_ready,
  input  logic [STATE_W-1:0] i_blk_data,
  input  logic               i_blk_last,
  output logic [STATE_W-1:0] o_rnd_in,
  output logic [RC_W-1:0]    o_rnd_rc,
  output logic [WORD_W-1:0]  o_rnd_key0,
  output logic [WORD_W-1:0]  o_rnd_key2,
  input  logic [STATE_W-1:0] i_rnd_out,
  output logic               o_busy,
  output logic               o_tag_valid,
  input  logic               i_tag_ready,
  output logic [STATE_W-1:0] o_tag
);

  localparam logic [CNT_W-1:0] c_last_cnt = CNT_W'(NR - 1);

  fsm_t               r_fsm;
  fsm_t               w_fsm_nxt;
  logic [STATE_W-1:0] r_state;
  logic [KEY_W-1:0]   r_key;
  logic [CNT_W-1:0]   r_rnd_cnt;
  logic               r_last_q;

  logic               w_accept;
  logic               w_key_load;
  logic               w_last_round;
  logic               w_rc_step;
  logic [WORD_W-1:0]  w_k_hi;
  logic [WORD_W-1:0]  w_k_lo;

  assign w_accept     = (r_fsm == IDLE) && i_blk_valid;
  assign w_key_load   = (r_fsm == IDLE) && i_key_we;
  assign w_last_round = (r_rnd_cnt == c_last_cnt);
  assign w_rc_step    = (r_fsm == ROUND);

  // State register of the sequencer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fsm <= IDLE;
    end else begin
      r_fsm <= w_fsm_nxt;
    end
  end

  // Next-state and handshake/status outputs.
  always_comb begin
    w_fsm_nxt   = r_fsm;
    o_blk_ready = 1'b0;
    o_busy      = 1'b0;
    o_tag_valid = 1'b0;
    case (r_fsm)
      IDLE: begin
        o_blk_ready = 1'b1;
        if (i_blk_valid) begin
          w_fsm_nxt = ROUND;
        end
      end
      ROUND: begin
        o_busy = 1'b1;
        if (w_last_round) begin
          w_fsm_nxt = r_last_q ? TAG : IDLE;
        end
      end
      TAG: begin
        o_tag_valid = 1'b1;
        if (i_tag_ready) begin
          w_fsm_nxt = IDLE;
        end
      end
      default: begin
        w_fsm_nxt = IDLE;
      end
    endcase
  end

  // Key register; writes only land while idle so a running message keeps its key.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_key <= '0;
    end else if (w_key_load) begin
      r_key <= i_key;
    end
  end

  // Chaining state, round counter and last-block flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= '0;
      r_rnd_cnt <= '0;
      r_last_q  <= 1'b0;
    end else begin
      case (r_fsm)
        IDLE: begin
          if (w_accept) begin
            r_state   <= r_state ^ i_blk_data;
            r_last_q  <= i_blk_last;
            r_rnd_cnt <= '0;
          end
        end
        ROUND: begin
          r_state   <= i_rnd_out;
          r_rnd_cnt <= r_rnd_cnt + CNT_W'(1);
        end
        TAG: begin
          if (i_tag_ready) begin
            r_state  <= '0;
            r_last_q <= 1'b0;
          end
        end
        default: begin
          r_state <= r_state;
        end
      endcase
    end
  end

  pelican_rc_lfsr #(
    .RC_INIT (RC_INIT)
  ) u_rc_lfsr (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_load (w_accept),
    .i_step (w_rc_step),
    .o_rc   (o_rnd_rc)
  );

  // Key words alternate order on odd rounds.
  assign w_k_hi     = r_key[63:32];
  assign w_k_lo     = r_key[31:0];
  assign o_rnd_key0 = r_rnd_cnt[0] ? w_k_lo : w_k_hi;
  assign o_rnd_key2 = r_rnd_cnt[0] ? w_k_hi : w_k_lo;

  assign o_rnd_in = r_state;
  assign o_tag    = r_state;

endmodule : pelican_round_ctrl
`default_nettype wire
